exu_oitf: RTL and testbench

Outstanding Instruction Track FIFO for the execution unit. Allocates an in-order tag (itag) to every instruction dispatched into the long pipe, which currently carries load/store. It holds each instruction's destination register until the long-pipe write-back arbiter retires it, and flags RAW/WAW hazards for instructions being dispatched. Sits between the dispatch stage (allocate, hazard query) and the long-pipe write-back arbiter (retire, oldest-entry info).

---
 rtl/exu_oitf_pkg.sv | 18 +
 rtl/exu_oitf_if.sv | 51 +++++
 rtl/exu_oitf_entry.sv | 57 +++++
 rtl/exu_oitf.sv | 98 +++++++++
 tb/tb_exu_oitf.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/exu_oitf_pkg.sv
// Shared widths and the entry record for the outstanding-instruction track FIFO.
// The OITF_HAZARD_CHECK_EN macro (used in exu_oitf and exu_oitf_entry) enables the per-entry rd compare.
package exu_oitf_pkg;

    localparam int OITF_DEPTH_DEFAULT = 4;
    localparam int ITAG_WIDTH         = $clog2(OITF_DEPTH_DEFAULT);
    localparam int RFIDX_WIDTH        = 5;

    typedef logic [ITAG_WIDTH-1:0]  itag_t;
    typedef logic [RFIDX_WIDTH-1:0] rfidx_t;

    typedef struct packed {
        logic   vld;
        logic   rdwen;
        rfidx_t rdidx;
    } oitf_entry_t;

endpackage

// File: rtl/exu_oitf_if.sv
// Dispatch / long-pipe write-back bundle around the OITF.
// The master side is dispatch plus the write-back arbiter; the slave side is the OITF itself.
interface exu_oitf_if;
    import exu_oitf_pkg::*;

    logic   dis_ena;
    logic   dis_ready;
    itag_t  dis_ptr;
    logic   dis_rdwen;
    rfidx_t dis_rdidx;

    logic   disp_rs1en;
    logic   disp_rs2en;
    rfidx_t disp_rs1idx;
    rfidx_t disp_rs2idx;
    rfidx_t disp_rdidx;
    logic   disp_rdwen;

    logic   oitfrd_match_disprs1;
    logic   oitfrd_match_disprs2;
    logic   oitfrd_match_disprd;

    logic   oitf_ret_ena;
    itag_t  oitf_ret_ptr;
    logic   oitf_ret_rdwen;
    rfidx_t oitf_ret_rdidx;

    logic   oitf_empty;
    logic   oitf_full;

    modport master (
        output dis_ena, dis_rdwen, dis_rdidx,
        output disp_rs1en, disp_rs2en, disp_rs1idx, disp_rs2idx, disp_rdidx, disp_rdwen,
        output oitf_ret_ena,
        input  dis_ready, dis_ptr,
        input  oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
        input  oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx,
        input  oitf_empty, oitf_full
    );

    modport slave (
        input  dis_ena, dis_rdwen, dis_rdidx,
        input  disp_rs1en, disp_rs2en, disp_rs1idx, disp_rs2idx, disp_rdidx, disp_rdwen,
        input  oitf_ret_ena,
        output dis_ready, dis_ptr,
        output oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd,
        output oitf_ret_ptr, oitf_ret_rdwen, oitf_ret_rdidx,
        output oitf_empty, oitf_full
    );

endinterface

// File: rtl/exu_oitf_entry.sv
// One OITF slot: valid/rdwen/rdidx registers and, with OITF_HAZARD_CHECK_EN, the
// rs1/rs2/rd hit compare against the dispatching instruction.
module exu_oitf_entry
    import exu_oitf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic        clr,
    input  logic        set_rdwen,
    input  rfidx_t      set_rdidx,
`ifdef OITF_HAZARD_CHECK_EN
    input  rfidx_t      q_rs1idx,
    input  rfidx_t      q_rs2idx,
    input  rfidx_t      q_rdidx,
    output logic        hit_rs1,
    output logic        hit_rs2,
    output logic        hit_rd,
`endif
    output oitf_entry_t entry
);

    oitf_entry_t entry_q, entry_d;

    // Allocate and retire never target the same slot in one cycle, so set simply wins.
    always_comb begin
        entry_d = entry_q;
        if (set) begin
            entry_d.vld   = 1'b1;
            entry_d.rdwen = set_rdwen;
            entry_d.rdidx = set_rdidx;
        end else if (clr) begin
            entry_d.vld   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

`ifdef OITF_HAZARD_CHECK_EN
    logic live;

    // x0 is hardwired zero, so a pending write to it is never a dependency.
    assign live    = entry_q.vld & entry_q.rdwen & (entry_q.rdidx != '0);
    assign hit_rs1 = live & (entry_q.rdidx == q_rs1idx);
    assign hit_rs2 = live & (entry_q.rdidx == q_rs2idx);
    assign hit_rd  = live & (entry_q.rdidx == q_rdidx);
`endif

endmodule

// File: rtl/exu_oitf.sv
// Outstanding Instruction Track FIFO: in-order itag allocation, retire tracking and
// RAW/WAW hazard flags for the long pipe. OITF_HAZARD_CHECK_EN selects exact rd compares.
module exu_oitf
    import exu_oitf_pkg::*;
#(
    parameter int OITF_DEPTH = OITF_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    exu_oitf_if.slave bus
);

    // Pointer MSB is the wrap flag; OITF_DEPTH must equal 2**ITAG_WIDTH so plain increment wraps.
    typedef logic [ITAG_WIDTH:0] ptr_t;

    ptr_t        alc_ptr_q, alc_ptr_d;
    ptr_t        ret_ptr_q, ret_ptr_d;
    logic        oitf_empty;
    logic        oitf_full;
    logic        alc_fire;
    logic        ret_fire;
    oitf_entry_t entries [OITF_DEPTH];
    oitf_entry_t ret_entry;

    always_comb begin
        oitf_empty = (alc_ptr_q == ret_ptr_q);
        oitf_full  = (alc_ptr_q[ITAG_WIDTH-1:0] == ret_ptr_q[ITAG_WIDTH-1:0]) &&
                     (alc_ptr_q[ITAG_WIDTH] != ret_ptr_q[ITAG_WIDTH]);
        alc_fire   = bus.dis_ena & ~oitf_full;
        ret_fire   = bus.oitf_ret_ena & ~oitf_empty;
        alc_ptr_d  = alc_fire ? alc_ptr_q + ptr_t'(1) : alc_ptr_q;
        ret_ptr_d  = ret_fire ? ret_ptr_q + ptr_t'(1) : ret_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alc_ptr_q <= '0;
            ret_ptr_q <= '0;
        end else begin
            alc_ptr_q <= alc_ptr_d;
            ret_ptr_q <= ret_ptr_d;
        end
    end

`ifdef OITF_HAZARD_CHECK_EN
    logic [OITF_DEPTH-1:0] hit_rs1;
    logic [OITF_DEPTH-1:0] hit_rs2;
    logic [OITF_DEPTH-1:0] hit_rd;
`endif

    for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_entry
        logic entry_set;
        logic entry_clr;

        assign entry_set = alc_fire & (alc_ptr_q[ITAG_WIDTH-1:0] == itag_t'(i));
        assign entry_clr = ret_fire & (ret_ptr_q[ITAG_WIDTH-1:0] == itag_t'(i));

        exu_oitf_entry u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .set       (entry_set),
            .clr       (entry_clr),
            .set_rdwen (bus.dis_rdwen),
            .set_rdidx (bus.dis_rdidx),
`ifdef OITF_HAZARD_CHECK_EN
            .q_rs1idx  (bus.disp_rs1idx),
            .q_rs2idx  (bus.disp_rs2idx),
            .q_rdidx   (bus.disp_rdidx),
            .hit_rs1   (hit_rs1[i]),
            .hit_rs2   (hit_rs2[i]),
            .hit_rd    (hit_rd[i]),
`endif
            .entry     (entries[i])
        );
    end

    assign ret_entry          = entries[ret_ptr_q[ITAG_WIDTH-1:0]];

    assign bus.dis_ready      = ~oitf_full;
    assign bus.dis_ptr        = alc_ptr_q[ITAG_WIDTH-1:0];
    assign bus.oitf_empty     = oitf_empty;
    assign bus.oitf_full      = oitf_full;
    assign bus.oitf_ret_ptr   = ret_ptr_q[ITAG_WIDTH-1:0];
    assign bus.oitf_ret_rdwen = ret_entry.vld & ret_entry.rdwen;
    assign bus.oitf_ret_rdidx = ret_entry.rdidx;

`ifdef OITF_HAZARD_CHECK_EN
    assign bus.oitfrd_match_disprs1 = bus.disp_rs1en & (|hit_rs1);
    assign bus.oitfrd_match_disprs2 = bus.disp_rs2en & (|hit_rs2);
    assign bus.oitfrd_match_disprd  = bus.disp_rdwen & (|hit_rd);
`else
    // Without comparators, anything outstanding is treated as a possible dependency.
    assign bus.oitfrd_match_disprs1 = bus.disp_rs1en & ~oitf_empty;
    assign bus.oitfrd_match_disprs2 = bus.disp_rs2en & ~oitf_empty;
    assign bus.oitfrd_match_disprd  = bus.disp_rdwen & ~oitf_empty;
`endif

endmodule

// File: tb/tb_exu_oitf.sv
// Self-checking bench for exu_oitf: directed fill/drain/wrap/hazard/reset steps then random
// traffic, all compared against a queue-based occupancy model (honours OITF_HAZARD_CHECK_EN).
module tb_exu_oitf;
    import exu_oitf_pkg::*;

    localparam int DEPTH = OITF_DEPTH_DEFAULT;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic       rdwen;
        logic [4:0] rdidx;
    } model_entry_t;

    model_entry_t mq[$];
    int           alc_cnt = 0;
    int           ret_cnt = 0;

    always #5 clk = ~clk;

    exu_oitf_if bus ();

    exu_oitf #(.OITF_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // A pending writer to idx exists; without the compare option any occupancy counts.
    function automatic logic model_hit(input logic [4:0] idx);
`ifdef OITF_HAZARD_CHECK_EN
        foreach (mq[k]) begin
            if (mq[k].rdwen && mq[k].rdidx != 5'd0 && mq[k].rdidx == idx) return 1'b1;
        end
        return 1'b0;
`else
        return (mq.size() != 0);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        int sz;
        sz = mq.size();
        checkOutput({tag, ".empty"},   32'(bus.oitf_empty),   32'(sz == 0));
        checkOutput({tag, ".full"},    32'(bus.oitf_full),    32'(sz == DEPTH));
        checkOutput({tag, ".ready"},   32'(bus.dis_ready),    32'(sz != DEPTH));
        checkOutput({tag, ".dis_ptr"}, 32'(bus.dis_ptr),      32'(alc_cnt % DEPTH));
        checkOutput({tag, ".ret_ptr"}, 32'(bus.oitf_ret_ptr), 32'(ret_cnt % DEPTH));
        checkOutput({tag, ".ret_rdwen"}, 32'(bus.oitf_ret_rdwen), 32'((sz != 0) ? mq[0].rdwen : 1'b0));
        if (sz != 0)
            checkOutput({tag, ".ret_rdidx"}, 32'(bus.oitf_ret_rdidx), 32'(mq[0].rdidx));
        checkOutput({tag, ".m_rs1"}, 32'(bus.oitfrd_match_disprs1), 32'(bus.disp_rs1en & model_hit(bus.disp_rs1idx)));
        checkOutput({tag, ".m_rs2"}, 32'(bus.oitfrd_match_disprs2), 32'(bus.disp_rs2en & model_hit(bus.disp_rs2idx)));
        checkOutput({tag, ".m_rd"},  32'(bus.oitfrd_match_disprd),  32'(bus.disp_rdwen & model_hit(bus.disp_rdidx)));
    endtask

    // Drive one cycle at negedge, check pre-edge outputs, then clock and advance the model.
    // Returns at posedge+1 with the inputs still applied.
    task automatic applyStimulus(input string tag,
                                 input logic alloc, input logic a_rdwen, input logic [4:0] a_rdidx,
                                 input logic ret,
                                 input logic q1en, input logic [4:0] q1,
                                 input logic q2en, input logic [4:0] q2,
                                 input logic qden, input logic [4:0] qd);
        logic alc_ok, ret_ok;
        model_entry_t e;
        @(negedge clk);
        bus.dis_ena      = alloc;
        bus.dis_rdwen    = a_rdwen;
        bus.dis_rdidx    = a_rdidx;
        bus.oitf_ret_ena = ret;
        bus.disp_rs1en   = q1en;
        bus.disp_rs1idx  = q1;
        bus.disp_rs2en   = q2en;
        bus.disp_rs2idx  = q2;
        bus.disp_rdwen   = qden;
        bus.disp_rdidx   = qd;
        #1;
        checkModel(tag);
        alc_ok = alloc && (mq.size() < DEPTH);
        ret_ok = ret && (mq.size() > 0);
        @(posedge clk);
        if (ret_ok) begin
            void'(mq.pop_front());
            ret_cnt++;
        end
        if (alc_ok) begin
            e.rdwen = a_rdwen;
            e.rdidx = a_rdidx;
            mq.push_back(e);
            alc_cnt++;
        end
        #1;
    endtask

    task automatic driveIdle();
        bus.dis_ena      = 1'b0;
        bus.dis_rdwen    = 1'b0;
        bus.dis_rdidx    = '0;
        bus.oitf_ret_ena = 1'b0;
        bus.disp_rs1en   = 1'b0;
        bus.disp_rs1idx  = '0;
        bus.disp_rs2en   = 1'b0;
        bus.disp_rs2idx  = '0;
        bus.disp_rdwen   = 1'b0;
        bus.disp_rdidx   = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        driveIdle();
        @(posedge clk);
        mq.delete();
        alc_cnt = 0;
        ret_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic e1, e2, ed;
        logic [4:0] i1, i2, id;
        rst_n = 1'b0;
        driveIdle();
        repeat (2) @(posedge clk);

        // Reset state
        doReset();
        checkOutput("rst.empty",     32'(bus.oitf_empty),     32'd1);
        checkOutput("rst.full",      32'(bus.oitf_full),      32'd0);
        checkOutput("rst.ready",     32'(bus.dis_ready),      32'd1);
        checkOutput("rst.dis_ptr",   32'(bus.dis_ptr),        32'd0);
        checkOutput("rst.ret_ptr",   32'(bus.oitf_ret_ptr),   32'd0);
        checkOutput("rst.ret_rdwen", 32'(bus.oitf_ret_rdwen), 32'd0);
        checkOutput("rst.ret_rdidx", 32'(bus.oitf_ret_rdidx), 32'd0);
        checkOutput("rst.m_rs1",     32'(bus.oitfrd_match_disprs1), 32'd0);

        // Fill with rd 5..8, then an ignored fifth dispatch
        for (int i = 0; i < 4; i++) begin
            checkOutput("fill.dis_ptr", 32'(bus.dis_ptr), 32'(i));
            applyStimulus("fill", 1'b1, 1'b1, 5'(5 + i), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        end
        checkOutput("fill.full",  32'(bus.oitf_full), 32'd1);
        checkOutput("fill.ready", 32'(bus.dis_ready), 32'd0);
        applyStimulus("over", 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("over.full",      32'(bus.oitf_full),      32'd1);
        checkOutput("over.ret_rdidx", 32'(bus.oitf_ret_rdidx), 32'd5);
        checkOutput("over.ret_ptr",   32'(bus.oitf_ret_ptr),   32'd0);

        // Drain in order, then an ignored extra retire
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain.rdidx", 32'(bus.oitf_ret_rdidx), 32'(5 + i));
            applyStimulus("drain", 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        end
        checkOutput("drain.empty", 32'(bus.oitf_empty), 32'd1);
        applyStimulus("drain_x", 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("drain_x.empty",   32'(bus.oitf_empty),   32'd1);
        checkOutput("drain_x.ret_ptr", 32'(bus.oitf_ret_ptr), 32'd0);

        // Wrap with occupancy one
        for (int i = 0; i < 6; i++) begin
            checkOutput("wrap.dis_ptr", 32'(bus.dis_ptr), 32'(i % 4));
            applyStimulus("wrap_a", 1'b1, 1'b1, 5'(20 + i), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            checkOutput("wrap.full", 32'(bus.oitf_full), 32'd0);
            applyStimulus("wrap_r", 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            checkOutput("wrap.empty", 32'(bus.oitf_empty), 32'd1);
        end

        // Hazard: outstanding x3 and x0 writers
        doReset();
        applyStimulus("hz_a3", 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus("hz_a0", 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus("hz_q", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3);
        checkOutput("hz.rs1", 32'(bus.oitfrd_match_disprs1), 32'd1);
`ifdef OITF_HAZARD_CHECK_EN
        checkOutput("hz.rs2", 32'(bus.oitfrd_match_disprs2), 32'd0);
`else
        checkOutput("hz.rs2", 32'(bus.oitfrd_match_disprs2), 32'd1);
`endif
        checkOutput("hz.rd",  32'(bus.oitfrd_match_disprd),  32'd1);
        applyStimulus("hz_q0", 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
`ifdef OITF_HAZARD_CHECK_EN
        checkOutput("hz0.rs1", 32'(bus.oitfrd_match_disprs1), 32'd0);
`else
        checkOutput("hz0.rs1", 32'(bus.oitfrd_match_disprs1), 32'd1);
`endif

        // Simultaneous allocate and retire at occupancy two
        doReset();
        applyStimulus("sim_a", 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus("sim_b", 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus("sim_ar", 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 5'd11);
        checkOutput("sim.empty",   32'(bus.oitf_empty),     32'd0);
        checkOutput("sim.full",    32'(bus.oitf_full),      32'd0);
        checkOutput("sim.dis_ptr", 32'(bus.dis_ptr),        32'd3);
        checkOutput("sim.ret_ptr", 32'(bus.oitf_ret_ptr),   32'd1);
        checkOutput("sim.rdidx",   32'(bus.oitf_ret_rdidx), 32'd11);

        // Mid-operation reset with three outstanding
        applyStimulus("mid_a", 1'b1, 1'b0, 5'd13, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("mid.dis_ptr", 32'(bus.dis_ptr), 32'd0);
        doReset();
        checkOutput("mid.empty",   32'(bus.oitf_empty),   32'd1);
        checkOutput("mid.ret_ptr", 32'(bus.oitf_ret_ptr), 32'd0);
        checkOutput("mid.dis_ptr", 32'(bus.dis_ptr),      32'd0);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            e1 = 1'($urandom_range(0, 1));
            e2 = 1'($urandom_range(0, 1));
            ed = 1'($urandom_range(0, 1));
            i1 = 5'($urandom_range(0, 7));
            i2 = 5'($urandom_range(0, 7));
            id = 5'($urandom_range(0, 7));
            applyStimulus("rnd", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 99) < 45),
                          e1, i1, e2, i2, ed, id);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
